// File: rtl/fifo_sched_pkg.sv
// Shared types and width helpers for the weighted round-robin FIFO drain scheduler.
package fifo_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } sched_state_t;

    // Index and counter fields never collapse to zero bits, even for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick_m.sv
// Combinational round-robin picker: first requesting index after 'last', wrapping modulo N,
// optionally skipping one excluded index.
module rr_pick_m
    import fifo_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]                req,
    input  logic [clog2_min1(N)-1:0]    last,
    input  logic                        exclude_en,
    input  logic [clog2_min1(N)-1:0]    exclude_idx,
    output logic                        found,
    output logic [clog2_min1(N)-1:0]    idx
);

    localparam int W = clog2_min1(N);

    logic [W-1:0] cand;

    // base < N and k <= N, so a single conditional subtract keeps the wrap modulo N.
    function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return W'(s);
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = wrap_add(last, k);
            if (!found && req[cand] && !(exclude_en && (cand == exclude_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_sched_m.sv
// Weighted round-robin drain scheduler: pops at most one FWFT FIFO per cycle and merges the
// items into a registered valid/ready stream tagged with the source index.
module fifo_rr_sched_m
    import fifo_sched_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic [31:0],
    parameter int  N_SRC          = 4,
    parameter int  QUANTUM        = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  DATA_ITEM_TYPE                   src_head [N_SRC],
    input  logic [N_SRC-1:0]                src_empty,
    input  logic [N_SRC-1:0]                src_rst_busy,
    output logic [N_SRC-1:0]                src_pop,
    output DATA_ITEM_TYPE                   out_data,
    output logic [clog2_min1(N_SRC)-1:0]    out_src,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int SRC_W = clog2_min1(N_SRC);
    localparam int CNT_W = clog2_min1(QUANTUM);
    localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(N_SRC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANTUM - 1);

    generate
        if (N_SRC < 2) begin : g_bad_nsrc
            $error("fifo_rr_sched_m: N_SRC must be >= 2");
        end
        if (QUANTUM < 1) begin : g_bad_quantum
            $error("fifo_rr_sched_m: QUANTUM must be >= 1");
        end
    endgenerate

    sched_state_t       state, state_n;
    logic [SRC_W-1:0]   grant, grant_n;
    logic [SRC_W-1:0]   last, last_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [N_SRC-1:0]   elig;
    logic               take;
    logic               pop_now;
    logic               pick_found, next_found;
    logic [SRC_W-1:0]   pick_idx, next_idx;

    assign elig = ~src_empty & ~src_rst_busy;
    assign take = ~out_valid | out_ready;

    // Plain pick for IDLE and for a granted source that ran dry.
    rr_pick_m #(.N(N_SRC)) u_pick_any (
        .req         (elig),
        .last        (last),
        .exclude_en  (1'b0),
        .exclude_idx (grant),
        .found       (pick_found),
        .idx         (pick_idx)
    );

    // Quantum hand-over: someone other than the current grant, if anyone is waiting.
    rr_pick_m #(.N(N_SRC)) u_pick_next (
        .req         (elig),
        .last        (last),
        .exclude_en  (1'b1),
        .exclude_idx (grant),
        .found       (next_found),
        .idx         (next_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= LAST_RST;
            cnt   <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n  = last;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = SERVE;
                    grant_n = pick_idx;
                    last_n  = pick_idx;
                    cnt_n   = '0;
                end
            end
            SERVE: begin
                if (take) begin
                    if (pop_now) begin
                        if (cnt == CNT_LAST) begin
                            cnt_n = '0;
                            if (next_found) begin
                                grant_n = next_idx;
                                last_n  = next_idx;
                            end
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end else if (pick_found) begin
                        grant_n = pick_idx;
                        last_n  = pick_idx;
                        cnt_n   = '0;
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Pop strobe depends only on registered state plus the live FIFO flags and out_ready.
    always_comb begin
        pop_now = 1'b0;
        src_pop = '0;
        if ((state == SERVE) && elig[grant] && take) begin
            pop_now        = 1'b1;
            src_pop[grant] = 1'b1;
        end
    end

    // Output register stage: a pop refills it in the same cycle the consumer drains it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (pop_now) begin
            out_valid <= 1'b1;
            out_data  <= src_head[grant];
            out_src   <= grant;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    a_pop_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(src_pop));

    a_pop_nonempty: assert property (@(posedge clk) disable iff (rst)
        ((src_pop & src_empty) == '0));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_data) && $stable(out_src)));

endmodule

// File: tb/tb_fifo_rr_sched_m.sv
// Bench for fifo_rr_sched_m: queue-based FIFO models, a per-source scoreboard and
// expected source-order lists derived from the weighted round-robin rules.
module tb_fifo_rr_sched_m;

    localparam int N = 4;
    localparam int Q = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    src_head [N];
    logic [N-1:0]   src_empty;
    logic [N-1:0]   src_rst_busy;
    logic [N-1:0]   src_pop;
    logic [31:0]    out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready;

    logic [31:0]    fq    [N][$];
    logic [31:0]    exp_q [N][$];
    int             exp_src [$];
    int             cons_tick [$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             tick_no  = 0;
    int             n_cons   = 0;
    int             seq      = 0;
    logic [N-1:0]   pop_acc;
    logic [N-1:0]   tk_pop;
    logic           tk_valid;
    logic [31:0]    tk_data;
    logic [1:0]     tk_src;
    logic [31:0]    ref_data;
    logic [1:0]     ref_src;

    always #5 clk = ~clk;

    fifo_rr_sched_m #(
        .DATA_ITEM_TYPE (logic [31:0]),
        .N_SRC          (N),
        .QUANTUM        (Q)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_head     (src_head),
        .src_empty    (src_empty),
        .src_rst_busy (src_rst_busy),
        .src_pop      (src_pop),
        .out_data     (out_data),
        .out_src      (out_src),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() == 0) begin
                src_empty[i] = 1'b1;
                src_head[i]  = 32'h0;
            end else begin
                src_empty[i] = 1'b0;
                src_head[i]  = fq[i][0];
            end
        end
    endtask

    task automatic load(input int s, input int n);
        logic [31:0] v;
        logic [7:0]  sb;
        for (int k = 0; k < n; k++) begin
            sb = 8'(s);
            seq++;
            v = {sb, 8'(seq), 16'($urandom)};
            fq[s].push_back(v);
            exp_q[s].push_back(v);
        end
        drive_src();
    endtask

    function automatic int pending();
        int t;
        t = 0;
        for (int i = 0; i < N; i++) t += exp_q[i].size();
        return t;
    endfunction

    // One clock: observe at the falling edge, update the FIFO models after the rising edge.
    task automatic tick();
        int s;
        @(negedge clk);
        tick_no++;
        tk_pop   = src_pop;
        tk_valid = out_valid;
        tk_data  = out_data;
        tk_src   = out_src;
        pop_acc  = pop_acc | src_pop;
        for (int i = 0; i < N; i++) begin
            if (src_pop[i] && fq[i].size() == 0) chk("pop_on_empty", 64'(src_pop[i]), 64'(0));
        end
        if (out_valid && out_ready) begin
            s = int'(out_src);
            n_cons++;
            cons_tick.push_back(tick_no);
            if (exp_src.size() > 0) chk("src_order", 64'(out_src), 64'(exp_src.pop_front()));
            if (exp_q[s].size() > 0) chk("item_data", 64'(out_data), 64'(exp_q[s].pop_front()));
            else chk("unexpected_item", 64'(out_data), 64'hDEAD_0000_0000);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (tk_pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        drive_src();
    endtask

    task automatic clear_models();
        for (int i = 0; i < N; i++) begin
            fq[i].delete();
            exp_q[i].delete();
        end
        exp_src.delete();
        cons_tick.delete();
        n_cons  = 0;
        pop_acc = '0;
        drive_src();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        out_ready    = 1'b1;
        src_rst_busy = '0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        tick_no = 0;
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (pending() > 0 && t < budget) begin
            tick();
            t++;
        end
        chk({tag, "_drained"}, 64'(t < budget), 64'(1));
        chk({tag, "_order_left"}, 64'(exp_src.size()), 64'(0));
    endtask

    initial begin
        rst          = 1'b1;
        out_ready    = 1'b0;
        src_rst_busy = '0;
        clear_models();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_src",   64'(out_src),   64'(0));
        chk("rst_src_pop",   64'(src_pop),   64'(0));

        // Round robin across four full sources: blocks of Q per source in index order.
        do_reset();
        for (int s = 0; s < N; s++) load(s, 8);
        for (int k = 0; k < 32; k++) exp_src.push_back((k / Q) % N);
        for (int t = 0; t < 60 && n_cons < 32; t++) tick();
        chk("rr_count", 64'(n_cons), 64'(32));
        // 32nd item becomes visible 33 edges after load, i.e. in the 34th observed cycle.
        chk("rr_last_tick", 64'((cons_tick.size() >= 32) ? cons_tick[31] : -1), 64'(34));
        chk("rr_first_tick", 64'((cons_tick.size() >= 1) ? cons_tick[0] : -1), 64'(3));

        // Single source: quantum wrap re-grants the same source without a gap.
        do_reset();
        load(2, 10);
        for (int k = 0; k < 10; k++) exp_src.push_back(2);
        drain("single", 60);
        chk("single_count", 64'(n_cons), 64'(10));
        chk("single_span", 64'((cons_tick.size() >= 10) ? cons_tick[9] - cons_tick[0] : -1), 64'(9));

        // Backpressure: output holds, no pops, then resumes in order.
        do_reset();
        out_ready = 1'b0;
        load(0, 3);
        load(1, 3);
        tick();
        tick();
        chk("bp_valid_up", 64'(out_valid), 64'(1));
        ref_data = out_data;
        ref_src  = out_src;
        chk("bp_first_item", 64'(ref_data), 64'(exp_q[0][0]));
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_data",  64'(tk_data),  64'(ref_data));
            chk("bp_hold_src",   64'(tk_src),   64'(ref_src));
            chk("bp_no_pop",     64'(tk_pop),   64'(0));
            chk("bp_hold_valid", 64'(tk_valid), 64'(1));
        end
        out_ready = 1'b1;
        exp_src = '{0, 0, 0, 1, 1, 1};
        drain("bp", 60);
        chk("bp_count", 64'(n_cons), 64'(6));

        // Mid-quantum empty: exactly one bubble before the next source.
        do_reset();
        load(1, 2);
        load(2, 4);
        exp_src = '{1, 1, 2, 2, 2, 2};
        drain("midq", 60);
        chk("midq_gap0", 64'((cons_tick.size() >= 2) ? cons_tick[1] - cons_tick[0] : -1), 64'(1));
        chk("midq_bubble", 64'((cons_tick.size() >= 3) ? cons_tick[2] - cons_tick[1] : -1), 64'(2));
        chk("midq_gap2", 64'((cons_tick.size() >= 4) ? cons_tick[3] - cons_tick[2] : -1), 64'(1));

        // Busy source is skipped, then served on its next turn once ready.
        do_reset();
        src_rst_busy = 4'b0001;
        load(0, 4);
        load(1, 8);
        load(2, 4);
        for (int k = 0; k < 16; k++) exp_src.push_back((k < 4) ? 1 : (k < 8) ? 2 : (k < 12) ? 1 : 0);
        pop_acc = '0;
        repeat (10) tick();
        chk("busy_never_popped", 64'(pop_acc[0]), 64'(0));
        src_rst_busy = '0;
        drain("busy", 80);

        // Asynchronous reset between edges clears the output at once; IDLE after release.
        do_reset();
        load(0, 4);
        load(1, 4);
        repeat (3) tick();
        chk("areset_pre_valid", 64'(out_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("areset_valid", 64'(out_valid), 64'(0));
        chk("areset_pop",   64'(src_pop),   64'(0));
        chk("areset_data",  64'(out_data),  64'(0));
        clear_models();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        tick_no = 0;
        load(3, 2);
        exp_src = '{3, 3};
        tick();
        chk("areset_idle_no_pop", 64'(tk_pop), 64'(0));
        tick();
        chk("areset_first_pop", 64'(tk_pop), 64'(4'b1000));
        drain("areset", 40);

        // Random backpressure with all sources full: source order is unaffected by stalls.
        do_reset();
        for (int s = 0; s < N; s++) load(s, 12);
        for (int k = 0; k < 48; k++) exp_src.push_back((k / Q) % N);
        begin
            int t;
            t = 0;
            while (pending() > 0 && t < 600) begin
                out_ready = ($urandom_range(0, 99) < 60);
                tick();
                t++;
            end
            chk("rand_full_done", 64'(t < 600), 64'(1));
        end
        out_ready = 1'b1;
        drain("rand_full", 40);
        chk("rand_full_count", 64'(n_cons), 64'(48));

        // Random lengths, random busy flags and random backpressure: no loss, per-source order.
        do_reset();
        begin
            int total;
            int t;
            total = 0;
            for (int s = 0; s < N; s++) begin
                int n;
                n = $urandom_range(0, 9);
                total += n;
                load(s, n);
            end
            t = 0;
            while (pending() > 0 && t < 800) begin
                out_ready = ($urandom_range(0, 99) < 70);
                for (int i = 0; i < N; i++) src_rst_busy[i] = ($urandom_range(0, 99) < 20);
                tick();
                t++;
            end
            src_rst_busy = '0;
            out_ready    = 1'b1;
            chk("rand_mix_done", 64'(t < 800), 64'(1));
            drain("rand_mix", 60);
            chk("rand_mix_count", 64'(n_cons), 64'(total));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
